// File: rtl/ex_mem_stage_if.sv
// Data-memory bus between the EX/MEM stage (master) and the data memory (slave).
// dmem_req is held with dmem_we/addr/wdata/be stable until the slave answers with dmem_ready for one cycle.
// dmem_rdata is only meaningful in that cycle.
interface ex_mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ready, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: registers execute results, performs LW/LB/SW/SB and NoC MMR writes,
// stalls upstream while a data-memory access is outstanding, and emits a registered write-back bundle.
module ex_mem_stage #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int MMR_ADDR_W     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ex_valid,
  input  logic [2:0]            ex_mem_flag,
  input  logic [31:0]           ex_mem_addr,
  input  logic [31:0]           ex_rd_data,
  input  logic [31:0]           ex_store_data,
  input  logic [4:0]            ex_rd_addr,
  input  logic                  ex_rd_we,
  input  logic                  ex_mmr_we,
  input  logic [31:0]           ex_inst,
  output logic                  mem_stall,
  ex_mem_stage_if.master        dmem,
  output logic                  mmr_we,
  output logic [MMR_ADDR_W-1:0] mmr_addr,
  output logic [31:0]           mmr_wdata,
  output logic                  wb_valid,
  output logic [4:0]            wb_rd_addr,
  output logic                  wb_rd_we,
  output logic [31:0]           wb_rd_data,
  output logic [31:0]           wb_inst,
  output logic                  misaligned_err,
  output logic                  bus_err,
  output logic [0:0]            state_dbg
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  localparam logic [2:0] FLAG_LW  = 3'b001;
  localparam logic [2:0] FLAG_LB  = 3'b111;
  localparam logic [2:0] FLAG_SW  = 3'b010;
  localparam logic [2:0] FLAG_SB  = 3'b100;
  localparam logic [2:0] FLAG_NOC = 3'b011;

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             req_we;
  logic [31:0]      req_addr;
  logic [31:0]      req_wdata;
  logic [3:0]       req_be;
  logic [1:0]       cap_off;
  logic             cap_lb;
  logic             cap_store;
  logic [4:0]       cap_rd_addr;
  logic             cap_rd_we;
  logic [31:0]      cap_inst;

  logic is_lw, is_lb, is_sw, is_sb, is_noc, is_mem, misalign, start_access;
  logic [7:0] lb_byte;

  always_comb begin
    is_lw        = (ex_mem_flag == FLAG_LW);
    is_lb        = (ex_mem_flag == FLAG_LB);
    is_sw        = (ex_mem_flag == FLAG_SW);
    is_sb        = (ex_mem_flag == FLAG_SB);
    is_noc       = (ex_mem_flag == FLAG_NOC);
    is_mem       = is_lw | is_lb | is_sw | is_sb;
    // Byte accesses can never be misaligned; only word accesses check the low bits.
    misalign     = (is_lw | is_sw) & (ex_mem_addr[1:0] != 2'b00);
    start_access = ex_valid & is_mem & ~misalign;
  end

  // Stalling in the capture cycle keeps the following instruction held upstream.
  assign mem_stall = (state == ACCESS) | ((state == IDLE) & start_access);

  assign dmem.dmem_req   = (state == ACCESS);
  assign dmem.dmem_we    = (state == ACCESS) & req_we;
  assign dmem.dmem_addr  = req_addr;
  assign dmem.dmem_wdata = req_wdata;
  assign dmem.dmem_be    = req_be;
  assign state_dbg       = state;

  always_comb begin
    lb_byte = dmem.dmem_rdata[7:0];
    case (cap_off)
      2'd1:    lb_byte = dmem.dmem_rdata[15:8];
      2'd2:    lb_byte = dmem.dmem_rdata[23:16];
      2'd3:    lb_byte = dmem.dmem_rdata[31:24];
      default: lb_byte = dmem.dmem_rdata[7:0];
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      cnt            <= '0;
      req_we         <= 1'b0;
      req_addr       <= '0;
      req_wdata      <= '0;
      req_be         <= '0;
      cap_off        <= '0;
      cap_lb         <= 1'b0;
      cap_store      <= 1'b0;
      cap_rd_addr    <= '0;
      cap_rd_we      <= 1'b0;
      cap_inst       <= '0;
      mmr_we         <= 1'b0;
      mmr_addr       <= '0;
      mmr_wdata      <= '0;
      wb_valid       <= 1'b0;
      wb_rd_addr     <= '0;
      wb_rd_we       <= 1'b0;
      wb_rd_data     <= '0;
      wb_inst        <= '0;
      misaligned_err <= 1'b0;
      bus_err        <= 1'b0;
    end else begin
      wb_valid       <= 1'b0;
      mmr_we         <= 1'b0;
      misaligned_err <= 1'b0;
      bus_err        <= 1'b0;
      if (state == IDLE) begin
        if (start_access) begin
          state       <= ACCESS;
          cnt         <= '0;
          req_we      <= is_sw | is_sb;
          req_addr    <= {ex_mem_addr[31:2], 2'b00};
          req_be      <= is_sb ? (4'b0001 << ex_mem_addr[1:0]) : 4'b1111;
          req_wdata   <= is_sb ? {4{ex_store_data[7:0]}} : ex_store_data;
          cap_off     <= ex_mem_addr[1:0];
          cap_lb      <= is_lb;
          cap_store   <= is_sw | is_sb;
          cap_rd_addr <= ex_rd_addr;
          cap_rd_we   <= ex_rd_we;
          cap_inst    <= ex_inst;
        end else if (ex_valid) begin
          wb_valid   <= 1'b1;
          wb_rd_addr <= ex_rd_addr;
          wb_inst    <= ex_inst;
          if (is_noc) begin
            mmr_we    <= ex_mmr_we;
            mmr_addr  <= ex_mem_addr[MMR_ADDR_W+1:2];
            mmr_wdata <= ex_store_data;
            wb_rd_we  <= 1'b0;
          end else if (misalign) begin
            misaligned_err <= 1'b1;
            wb_rd_we       <= 1'b0;
          end else begin
            wb_rd_we   <= ex_rd_we;
            wb_rd_data <= ex_rd_data;
          end
        end
      end else begin
        // Ready in the expiry cycle still completes normally.
        if (dmem.dmem_ready) begin
          state      <= IDLE;
          req_we     <= 1'b0;
          wb_valid   <= 1'b1;
          wb_rd_addr <= cap_rd_addr;
          wb_inst    <= cap_inst;
          if (cap_store) begin
            wb_rd_we <= 1'b0;
          end else begin
            wb_rd_we   <= cap_rd_we;
            wb_rd_data <= cap_lb ? {{24{lb_byte[7]}}, lb_byte} : dmem.dmem_rdata;
          end
        end else if (cnt == CNT_LAST) begin
          state      <= IDLE;
          req_we     <= 1'b0;
          bus_err    <= 1'b1;
          wb_valid   <= 1'b1;
          wb_rd_we   <= 1'b0;
          wb_rd_addr <= cap_rd_addr;
          wb_inst    <= cap_inst;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed cases, a short random mix, timeout and mid-access reset.
module tb_ex_mem_stage;
  localparam int TO = 16;
  localparam int EW = 41; // {chk_data, misal, berr, rd_we, rd_addr[4:0], rd_data[31:0]}

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ex_valid = 1'b0;
  logic [2:0]  ex_mem_flag = '0;
  logic [31:0] ex_mem_addr = '0;
  logic [31:0] ex_rd_data = '0;
  logic [31:0] ex_store_data = '0;
  logic [4:0]  ex_rd_addr = '0;
  logic        ex_rd_we = 1'b0;
  logic        ex_mmr_we = 1'b0;
  logic [31:0] ex_inst = '0;
  logic        mem_stall;
  logic        mmr_we;
  logic [7:0]  mmr_addr;
  logic [31:0] mmr_wdata;
  logic        wb_valid;
  logic [4:0]  wb_rd_addr;
  logic        wb_rd_we;
  logic [31:0] wb_rd_data;
  logic [31:0] wb_inst;
  logic        misaligned_err;
  logic        bus_err;
  logic [0:0]  state_dbg;

  ex_mem_stage_if dmem_bus ();

  ex_mem_stage #(.TIMEOUT_CYCLES(TO), .MMR_ADDR_W(8)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_mem_flag(ex_mem_flag), .ex_mem_addr(ex_mem_addr),
    .ex_rd_data(ex_rd_data), .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr),
    .ex_rd_we(ex_rd_we), .ex_mmr_we(ex_mmr_we), .ex_inst(ex_inst),
    .mem_stall(mem_stall), .dmem(dmem_bus.master),
    .mmr_we(mmr_we), .mmr_addr(mmr_addr), .mmr_wdata(mmr_wdata),
    .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr), .wb_rd_we(wb_rd_we),
    .wb_rd_data(wb_rd_data), .wb_inst(wb_inst),
    .misaligned_err(misaligned_err), .bus_err(bus_err), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic exp_push(input logic chk_data, input logic misal, input logic berr,
                          input logic rd_we, input logic [4:0] rd, input logic [31:0] data);
    exp_q.push_back({chk_data, misal, berr, rd_we, rd, data});
  endtask

  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (reset && wb_valid) begin
      if (exp_q.size() == 0) begin
        check("wb_unexpected", 64'(1), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("wb_rd_addr", 64'(wb_rd_addr), 64'(e[36:32]));
        check("wb_rd_we", 64'(wb_rd_we), 64'(e[37]));
        check("bus_err", 64'(bus_err), 64'(e[38]));
        check("misaligned_err", 64'(misaligned_err), 64'(e[39]));
        if (e[40]) check("wb_rd_data", 64'(wb_rd_data), 64'(e[31:0]));
      end
    end
  end

  // ---------------- memory responder ----------------
  int          acc_cyc = 0;
  int          ready_after = 0; // 0 = never answer
  logic [31:0] resp_data = '0;
  logic [31:0] seen_addr, seen_wdata;
  logic [3:0]  seen_be;
  logic        seen_we;

  initial begin
    dmem_bus.dmem_ready = 1'b0;
    dmem_bus.dmem_rdata = '0;
  end

  always @(negedge clk) begin
    if (dmem_bus.dmem_req) begin
      acc_cyc++;
      if (acc_cyc == 1) begin
        seen_addr  = dmem_bus.dmem_addr;
        seen_wdata = dmem_bus.dmem_wdata;
        seen_be    = dmem_bus.dmem_be;
        seen_we    = dmem_bus.dmem_we;
      end else begin
        check("dmem_hold_ctl", 64'({dmem_bus.dmem_we, dmem_bus.dmem_be, dmem_bus.dmem_addr}),
              64'({seen_we, seen_be, seen_addr}));
        check("dmem_hold_wdata", 64'(dmem_bus.dmem_wdata), 64'(seen_wdata));
      end
      dmem_bus.dmem_ready = (acc_cyc == ready_after);
      dmem_bus.dmem_rdata = (acc_cyc == ready_after) ? resp_data : $urandom;
    end else begin
      acc_cyc = 0;
      dmem_bus.dmem_ready = 1'b0;
      dmem_bus.dmem_rdata = '0;
    end
  end

  // ---------------- driver ----------------
  logic        got_mmr_we;
  logic [7:0]  got_mmr_addr;
  logic [31:0] got_mmr_wdata;

  task automatic issue(input logic [2:0] flag, input logic [31:0] addr, input logic [31:0] rd_data,
                       input logic [31:0] st_data, input logic [4:0] rd, input logic rd_we,
                       input logic mmr_we_in, output int stall_cnt, output int lat, output int req_cnt);
    logic [31:0] inst_v;
    bit seen;
    inst_v = $urandom;
    seen = 1'b0;
    @(negedge clk);
    ex_valid = 1'b1; ex_mem_flag = flag; ex_mem_addr = addr; ex_rd_data = rd_data;
    ex_store_data = st_data; ex_rd_addr = rd; ex_rd_we = rd_we; ex_mmr_we = mmr_we_in; ex_inst = inst_v;
    #1;
    stall_cnt = int'(mem_stall);
    lat = 0;
    req_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      // Junk on ex_valid while the access is outstanding must be ignored.
      ex_valid = dmem_bus.dmem_req & 1'($urandom_range(0, 1));
      #1;
      lat++;
      if (wb_valid) begin
        seen = 1'b1;
        got_mmr_we = mmr_we; got_mmr_addr = mmr_addr; got_mmr_wdata = mmr_wdata;
        check("wb_inst", 64'(wb_inst), 64'(inst_v));
        break;
      end
      stall_cnt += int'(mem_stall);
      req_cnt += int'(dmem_bus.dmem_req);
    end
    if (!seen) check("wb_wait", 64'(0), 64'(1));
    ex_valid = 1'b0;
    @(negedge clk);
    #1;
    check("pulses_drop", 64'({wb_valid, mmr_we, misaligned_err, bus_err}), 64'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int st, lt, rq, kind, rd;
    logic [31:0] a, d, sh;
    #3;
    check("rst_outputs", 64'({wb_valid, dmem_bus.dmem_req, mem_stall, bus_err, misaligned_err, mmr_we, state_dbg}), 64'(0));
    check("rst_wb_data", 64'(wb_rd_data), 64'(0));
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // ALU op
    exp_push(1, 0, 0, 1, 5'd5, 32'h12345678);
    issue(3'b000, 32'h0, 32'h12345678, 32'h0, 5'd5, 1'b1, 1'b0, st, lt, rq);
    check("alu_lat", 64'(lt), 64'(1));
    check("alu_req", 64'(rq), 64'(0));
    check("alu_stall", 64'(st), 64'(0));

    // LB sign extend, ready on 3rd access cycle
    ready_after = 3; resp_data = 32'h80FF0011;
    exp_push(1, 0, 0, 1, 5'd7, 32'hFFFFFF80);
    issue(3'b111, 32'h103, 32'h0, 32'h0, 5'd7, 1'b1, 1'b0, st, lt, rq);
    check("lb_addr", 64'(seen_addr), 64'(32'h100));
    check("lb_we", 64'(seen_we), 64'(0));
    check("lb_stall", 64'(st), 64'(4));
    check("lb_lat", 64'(lt), 64'(4));
    check("lb_req", 64'(rq), 64'(3));

    // SB, immediate ready
    ready_after = 1;
    exp_push(0, 0, 0, 0, 5'd9, 32'h0);
    issue(3'b100, 32'h22, 32'h0, 32'h000000AB, 5'd9, 1'b1, 1'b0, st, lt, rq);
    check("sb_we", 64'(seen_we), 64'(1));
    check("sb_be", 64'(seen_be), 64'(4'b0100));
    check("sb_wdata", 64'(seen_wdata), 64'(32'hABABABAB));
    check("sb_addr", 64'(seen_addr), 64'(32'h20));
    check("sb_lat", 64'(lt), 64'(2));

    // SW aligned, ready on 2nd cycle
    ready_after = 2;
    exp_push(0, 0, 0, 0, 5'd3, 32'h0);
    issue(3'b010, 32'h1004, 32'h0, 32'hCAFEF00D, 5'd3, 1'b1, 1'b0, st, lt, rq);
    check("sw_ctl", 64'({seen_we, seen_be, seen_addr}), 64'({1'b1, 4'b1111, 32'h1004}));
    check("sw_wdata", 64'(seen_wdata), 64'(32'hCAFEF00D));

    // Misaligned LW / SW
    exp_push(0, 1, 0, 0, 5'd4, 32'h0);
    issue(3'b001, 32'h2, 32'h0, 32'h0, 5'd4, 1'b1, 1'b0, st, lt, rq);
    check("mis_lw_req", 64'(rq), 64'(0));
    check("mis_lw_lat", 64'(lt), 64'(1));
    check("mis_lw_stall", 64'(st), 64'(0));
    exp_push(0, 1, 0, 0, 5'd6, 32'h0);
    issue(3'b010, 32'h41, 32'h0, 32'h55, 5'd6, 1'b1, 1'b0, st, lt, rq);
    check("mis_sw_req", 64'(rq), 64'(0));

    // loadnoc
    exp_push(0, 0, 0, 0, 5'd2, 32'h0);
    issue(3'b011, 32'h40, 32'h0, 32'h0000DEAD, 5'd2, 1'b1, 1'b1, st, lt, rq);
    check("noc_mmr", 64'({got_mmr_we, got_mmr_addr, got_mmr_wdata}), 64'({1'b1, 8'h10, 32'h0000DEAD}));
    check("noc_req", 64'(rq), 64'(0));
    check("noc_lat", 64'(lt), 64'(1));

    // Timeout: never ready
    ready_after = 0;
    exp_push(0, 0, 1, 0, 5'd8, 32'h0);
    issue(3'b010, 32'h200, 32'h0, 32'h11, 5'd8, 1'b1, 1'b0, st, lt, rq);
    check("to_req", 64'(rq), 64'(TO));
    check("to_lat", 64'(lt), 64'(TO + 1));
    check("to_state", 64'(state_dbg), 64'(0));

    // Ready exactly in the expiry cycle wins
    ready_after = TO; resp_data = 32'h5A5A1234;
    exp_push(1, 0, 0, 1, 5'd10, 32'h5A5A1234);
    issue(3'b001, 32'h300, 32'h0, 32'h0, 5'd10, 1'b1, 1'b0, st, lt, rq);
    check("edge_lat", 64'(lt), 64'(TO + 1));

    // Random mix of ALU / LW / LB
    for (int k = 0; k < 12; k++) begin
      kind = $urandom_range(0, 2);
      rd = $urandom_range(1, 31);
      d = $urandom;
      a = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      ready_after = $urandom_range(1, 5);
      resp_data = $urandom;
      if (kind == 0) begin
        exp_push(1, 0, 0, 1, 5'(rd), d);
        issue(3'b000, a, d, 32'h0, 5'(rd), 1'b1, 1'b0, st, lt, rq);
        check("rnd_alu_lat", 64'(lt), 64'(1));
      end else if (kind == 1) begin
        exp_push(1, 0, 0, 1, 5'(rd), resp_data);
        issue(3'b001, a, d, 32'h0, 5'(rd), 1'b1, 1'b0, st, lt, rq);
        check("rnd_lw_lat", 64'(lt), 64'(1 + ready_after));
      end else begin
        a[1:0] = 2'($urandom_range(0, 3));
        sh = resp_data >> (8 * a[1:0]);
        exp_push(1, 0, 0, 1, 5'(rd), {{24{sh[7]}}, sh[7:0]});
        issue(3'b111, a, d, 32'h0, 5'(rd), 1'b1, 1'b0, st, lt, rq);
        check("rnd_lb_addr", 64'(seen_addr), 64'({a[31:2], 2'b00}));
      end
    end

    // Reset in the middle of an access
    ready_after = 0;
    @(negedge clk);
    ex_valid = 1'b1; ex_mem_flag = 3'b010; ex_mem_addr = 32'h80; ex_store_data = 32'h1;
    @(negedge clk);
    ex_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1 check("req_before_rst", 64'(dmem_bus.dmem_req), 64'(1));
    #2 reset = 1'b0;
    #1;
    check("req_after_rst", 64'(dmem_bus.dmem_req), 64'(0));
    check("rst_mid_outs", 64'({wb_valid, mem_stall, bus_err, state_dbg}), 64'(0));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Recovery after reset
    exp_push(1, 0, 0, 0, 5'd12, 32'h0BADBEEF);
    issue(3'b101, 32'h0, 32'h0BADBEEF, 32'h0, 5'd12, 1'b0, 1'b0, st, lt, rq);
    check("post_rst_lat", 64'(lt), 64'(1));

    check("sb_drain", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
Pipeline stage directly downstream of the execute stage. It registers the execute results and performs the data-memory access selected by the 3-bit memory flag: LW, LB, SW, SB, or loadnoc (store rs2 into the NoC memory-mapped register space). It then hands a registered result to write-back. While a data-memory access is outstanding, it stalls the upstream stages.

Parameters:
TIMEOUT_CYCLES, 16, ACCESS cycles without dmem_ready before the access is aborted (minimum 2)
MMR_ADDR_W, 8, width of the word-indexed MMR address driven to the NoC register block

Ports:
clk  input  1  stage clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
ex_valid  input  1  execute outputs are valid this cycle
ex_mem_flag  input  3  000 none, 001 LW, 111 LB, 010 SW, 100 SB, 011 loadnoc; other codes are treated as none
ex_mem_addr  input  32  computed byte address
ex_rd_data  input  32  ALU / U-type result
ex_store_data  input  32  store data (SW/SB/loadnoc)
ex_rd_addr  input  5  destination register
ex_rd_we  input  1  destination write enable
ex_mmr_we  input  1  MMR write enable for loadnoc
ex_inst  input  32  instruction word
mem_stall  output  1  upstream must hold its outputs
dmem_req  output  1  data-memory request
dmem_we  output  1  1 = write
dmem_addr  output  32  word-aligned address ({addr[31:2],2'b00})
dmem_wdata  output  32  write data
dmem_be  output  4  byte enables
dmem_ready  input  1  access complete this cycle
dmem_rdata  input  32  read word, valid with dmem_ready
mmr_we  output  1  one-cycle MMR write strobe
mmr_addr  output  MMR_ADDR_W  ex_mem_addr[MMR_ADDR_W+1:2]
mmr_wdata  output  32  MMR write data
wb_valid  output  1  write-back bundle valid (one-cycle pulse)
wb_rd_addr  output  5  destination register
wb_rd_we  output  1  register write enable
wb_rd_data  output  32  data to write
wb_inst  output  32  instruction word
misaligned_err  output  1  one-cycle pulse
bus_err  output  1  one-cycle pulse on timeout

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, FSM to IDLE, timeout counter 0. A reset during ACCESS drops dmem_req immediately and produces no write-back.
- FSM states:
  - IDLE: mem_stall=0. If ex_valid=1, capture all ex_* inputs and pick the next state from the flag.
  - ACCESS: dmem_req=1 and mem_stall=1. Address, write enable, byte enables and data are held stable until dmem_ready.
- Capture in IDLE, by flag:
  - Flag none: next cycle wb_valid=1 with wb_rd_data=ex_rd_data, wb_rd_we=ex_rd_we. Stay in IDLE. Latency 1.
  - LW/SW with addr[1:0]≠00: no access. Next cycle wb_valid=1, wb_rd_we=0, misaligned_err=1.
  - LW/LB/SW/SB aligned: next cycle state=ACCESS, dmem_req=1.
  - loadnoc: next cycle mmr_we=ex_mmr_we (1 cycle), mmr_wdata=ex_store_data, wb_valid=1, wb_rd_we=0. No dmem access. Latency 1.
- ACCESS, store behaviour:
  - SW: dmem_we=1, be=1111, wdata=ex_store_data.
  - SB: be=0001<<addr[1:0], wdata={4{ex_store_data[7:0]}}.
- ACCESS, completion:
  - dmem_ready is sampled every ACCESS cycle, including the first, so the minimum access is 1 cycle.
  - On ready: dmem_req drops the next cycle, state goes to IDLE, and wb_valid=1 the same next cycle.
  - Load data: LW gives wb_rd_data=dmem_rdata. LB gives the byte rdata[8*addr[1:0]+:8], sign-extended. wb_rd_we=ex_rd_we.
  - Store data: wb_rd_we=0.
  - Total load-use latency = 1 (capture) + N (ACCESS) cycles.
- Timeout: the counter increments each ACCESS cycle without ready. On reaching TIMEOUT_CYCLES the access is aborted: dmem_req=0, bus_err=1, wb_valid=1, wb_rd_we=0, state goes to IDLE. Ready arriving in the same cycle as expiry wins (normal completion).
- mem_stall is combinational: 1 in ACCESS, and also in the capture cycle when an aligned load or store is accepted. This prevents the next instruction from being lost.
- No new instruction is accepted during ACCESS. ex_valid is ignored there, because upstream holds its outputs.
- wb_valid, mmr_we, misaligned_err and bus_err are single-cycle pulses. The other wb_* outputs hold their value until the next wb_valid.

Test Plan:
- ALU op: flag 000, rd_data=0x12345678, rd=5, we=1 -> next cycle wb_valid=1, wb_rd_data=0x12345678, wb_rd_addr=5, no dmem_req.
- LB sign-extend: flag 111, addr=0x103, dmem_ready after 3 cycles with rdata=0x80FF0011 -> dmem_addr=0x100, mem_stall high 4 cycles, wb_rd_data=0xFFFFFF80.
- SB: flag 100, addr=0x22, store_data=0xAB, ready immediately -> dmem_we=1, be=0100, wdata=0xABABABAB, wb_rd_we=0.
- Misaligned LW: addr=0x0002 -> no dmem_req, misaligned_err pulse, wb_rd_we=0.
- loadnoc: flag 011, addr=0x40, store_data=0xDEAD, mmr_we=1 -> mmr_we pulse, mmr_addr=0x10, mmr_wdata=0xDEAD, no dmem_req.
- Timeout/reset: SW with ready never asserted -> bus_err at cycle TIMEOUT_CYCLES, back to IDLE. Repeat and pull reset low mid-ACCESS -> dmem_req=0 immediately, no wb_valid.
